// File: rtl/digdug_hiscore_xfer_if.sv
// rtl/digdug_hiscore_xfer_if.sv - request, host buffer and core high-score port bundle
interface digdug_hiscore_xfer_if;
    logic        LOAD_REQ;
    logic        SAVE_REQ;
    logic [10:0] BUF_AD;
    logic [7:0]  BUF_RD;
    logic [7:0]  BUF_WD;
    logic        BUF_WE;
    logic [10:0] hs_address;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic        hs_write;
    logic        hs_access;
    logic        PAUSE_REQ;
    logic        BUSY;
    logic        DONE;

    modport master (
        input  LOAD_REQ, SAVE_REQ, BUF_RD, hs_data_out,
        output BUF_AD, BUF_WD, BUF_WE, hs_address, hs_data_in, hs_write,
        output hs_access, PAUSE_REQ, BUSY, DONE
    );

    modport slave (
        output LOAD_REQ, SAVE_REQ, BUF_RD, hs_data_out,
        input  BUF_AD, BUF_WD, BUF_WE, hs_address, hs_data_in, hs_write,
        input  hs_access, PAUSE_REQ, BUSY, DONE
    );
endinterface

// File: rtl/digdug_hiscore_xfer.sv
// rtl/digdug_hiscore_xfer.sv - high-score block copier between host buffer and DigDug core RAM
module digdug_hiscore_xfer #(
    parameter logic [10:0] HS_BASE = 11'h000,
    parameter logic [10:0] HS_LEN  = 11'd64,
    parameter int          RD_LAT  = 2,
    parameter int          SETTLE  = 4
) (
    input  logic                         MCLK,
    input  logic                         RESET,
    digdug_hiscore_xfer_if.master        xf
);
    typedef enum logic [2:0] {
        IDLE, SETTLE_W, LD_FETCH, LD_WRITE, SV_ADDR, SV_STORE, FIN
    } state_t;

    localparam logic [10:0] LAST_IDX    = HS_LEN - 11'd1;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] LAT_LAST    = 16'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic        dir_load_q, dir_load_d;
    logic [10:0] idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pause_q, pause_d, busy_q, busy_d, done_q, done_d;
    logic        access_q, access_d, hs_write_q, hs_write_d, buf_we_q, buf_we_d;
    logic [10:0] buf_ad_q, buf_ad_d, hs_addr_q, hs_addr_d;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            dir_load_q <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            pause_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            access_q   <= 1'b0;
            hs_write_q <= 1'b0;
            buf_we_q   <= 1'b0;
            buf_ad_q   <= '0;
            hs_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            dir_load_q <= dir_load_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pause_q    <= pause_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            access_q   <= access_d;
            hs_write_q <= hs_write_d;
            buf_we_q   <= buf_we_d;
            buf_ad_q   <= buf_ad_d;
            hs_addr_q  <= hs_addr_d;
        end
    end

    // cnt_q times both the pause settle window and the core read latency
    always_comb begin
        state_d    = state_q;
        dir_load_d = dir_load_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (xf.LOAD_REQ || xf.SAVE_REQ) begin
                    state_d    = SETTLE_W;
                    dir_load_d = xf.LOAD_REQ;
                    idx_d      = '0;
                    cnt_d      = '0;
                end
            end
            SETTLE_W: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = dir_load_q ? LD_FETCH : SV_ADDR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            LD_FETCH: state_d = LD_WRITE;
            LD_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 11'd1;
                    state_d = LD_FETCH;
                end
            end
            SV_ADDR: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = SV_STORE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SV_STORE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 11'd1;
                    state_d = SV_ADDR;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe leaves a flop
    always_comb begin
        pause_d    = (state_d != IDLE) && (state_d != FIN);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        access_d   = (state_d == LD_FETCH) || (state_d == LD_WRITE) ||
                     (state_d == SV_ADDR)  || (state_d == SV_STORE);
        hs_write_d = (state_d == LD_WRITE);
        buf_we_d   = (state_d == SV_STORE);
        buf_ad_d   = ((state_d == LD_FETCH) || (state_d == SV_STORE)) ? idx_d : 11'd0;
        hs_addr_d  = ((state_d == LD_WRITE) || (state_d == SV_ADDR) || (state_d == SV_STORE))
                     ? HS_BASE + idx_d : 11'd0;
    end

    assign xf.PAUSE_REQ  = pause_q;
    assign xf.BUSY       = busy_q;
    assign xf.DONE       = done_q;
    assign xf.hs_access  = access_q;
    assign xf.hs_write   = hs_write_q;
    assign xf.BUF_WE     = buf_we_q;
    assign xf.BUF_AD     = buf_ad_q;
    assign xf.hs_address = hs_addr_q;
    assign xf.hs_data_in = hs_write_q ? xf.BUF_RD : 8'h00;
    assign xf.BUF_WD     = buf_we_q ? xf.hs_data_out : 8'h00;
endmodule

// File: tb/tb_digdug_hiscore_xfer.sv
// tb/tb_digdug_hiscore_xfer.sv - directed bench with cycle-offset reference model for digdug_hiscore_xfer
module tb_digdug_hiscore_xfer;
    localparam logic [10:0] LEN    = 11'd4;
    localparam int          RD_LAT = 2;
    localparam int          SETTLE = 4;
    localparam logic [10:0] BASE0  = 11'h000;
    localparam logic [10:0] BASE1  = 11'h7FE;

    logic MCLK  = 1'b0;
    logic RESET = 1'b1;
    always #5 MCLK = ~MCLK;

    digdug_hiscore_xfer_if hs0 ();
    digdug_hiscore_xfer_if hs1 ();

    digdug_hiscore_xfer #(.HS_BASE(BASE0), .HS_LEN(LEN), .RD_LAT(RD_LAT), .SETTLE(SETTLE))
        dut0 (.MCLK(MCLK), .RESET(RESET), .xf(hs0));
    digdug_hiscore_xfer #(.HS_BASE(BASE1), .HS_LEN(LEN), .RD_LAT(RD_LAT), .SETTLE(SETTLE))
        dut1 (.MCLK(MCLK), .RESET(RESET), .xf(hs1));

    logic        ld [2];
    logic        sv [2];
    logic        mem_init;
    logic [7:0]  init_buf [4];
    logic [7:0]  init_ram [4];
    logic [7:0]  hbuf [2][2048];
    logic [7:0]  ram  [2][2048];
    logic [7:0]  buf_rd [2];
    logic [7:0]  lat_pipe [2][RD_LAT];
    logic [43:0] obs [2];

    assign hs0.LOAD_REQ    = ld[0];
    assign hs0.SAVE_REQ    = sv[0];
    assign hs0.BUF_RD      = buf_rd[0];
    assign hs0.hs_data_out = lat_pipe[0][RD_LAT-1];
    assign hs1.LOAD_REQ    = ld[1];
    assign hs1.SAVE_REQ    = sv[1];
    assign hs1.BUF_RD      = buf_rd[1];
    assign hs1.hs_data_out = lat_pipe[1][RD_LAT-1];

    // {PAUSE,BUSY,DONE,access,hs_write,BUF_WE,BUF_AD,hs_address,hs_data_in,BUF_WD}
    assign obs[0] = {hs0.PAUSE_REQ, hs0.BUSY, hs0.DONE, hs0.hs_access, hs0.hs_write, hs0.BUF_WE,
                     hs0.BUF_AD, hs0.hs_address, hs0.hs_data_in, hs0.BUF_WD};
    assign obs[1] = {hs1.PAUSE_REQ, hs1.BUSY, hs1.DONE, hs1.hs_access, hs1.hs_write, hs1.BUF_WE,
                     hs1.BUF_AD, hs1.hs_address, hs1.hs_data_in, hs1.BUF_WD};

    function automatic logic [10:0] base_of(int i);
        return (i == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int tlen(bit is_load);
        return SETTLE + (is_load ? 2 : RD_LAT + 1) * int'(LEN) + 1;
    endfunction

    // Host buffer (1-cycle read) and core RAM (RD_LAT read) models
    always @(posedge MCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_init) begin
                for (int a = 0; a < 2048; a++) begin
                    hbuf[i][a] <= 8'h00;
                    ram[i][a]  <= 8'h00;
                end
                for (int j = 0; j < 4; j++) begin
                    hbuf[i][j]                    <= init_buf[j];
                    ram[i][base_of(i) + 11'(j)]   <= init_ram[j];
                end
            end else begin
                buf_rd[i]      <= hbuf[i][obs[i][37:27]];
                lat_pipe[i][0] <= ram[i][obs[i][26:16]];
                for (int k = 1; k < RD_LAT; k++) lat_pipe[i][k] <= lat_pipe[i][k-1];
                if (obs[i][39]) ram[i][obs[i][26:16]]  <= obs[i][15:8];
                if (obs[i][38]) hbuf[i][obs[i][37:27]] <= obs[i][7:0];
            end
        end
    end

    int cyc = 0;
    bit act [2];
    bit dir [2];
    int s   [2];

    always @(posedge MCLK) cyc <= cyc + 1;

    always @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            act[0] <= 1'b0;
            act[1] <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!(act[i] && (cyc - s[i] <= tlen(dir[i]))) && (ld[i] || sv[i])) begin
                    act[i] <= 1'b1;
                    s[i]   <= cyc;
                    dir[i] <= ld[i];
                end
            end
        end
    end

    // Expected outputs from the cycle offset since the accepted request
    function automatic logic [43:0] model_out(int i);
        logic [43:0] v;
        logic [10:0] a;
        int k, per, j, b, ph;
        v = '0;
        if (!act[i]) return v;
        k   = cyc - s[i];
        per = dir[i] ? 2 : RD_LAT + 1;
        if (k < 1 || k > tlen(dir[i])) return v;
        v[42] = 1'b1;
        if (k == tlen(dir[i])) begin
            v[41] = 1'b1;
            return v;
        end
        v[43] = 1'b1;
        if (k <= SETTLE) return v;
        j  = k - SETTLE - 1;
        b  = j / per;
        ph = j % per;
        a  = base_of(i) + 11'(b);
        v[40] = 1'b1;
        if (dir[i]) begin
            if (ph == 0) begin
                v[37:27] = 11'(b);
            end else begin
                v[39]    = 1'b1;
                v[26:16] = a;
                v[15:8]  = hbuf[i][b];
            end
        end else begin
            v[26:16] = a;
            if (ph == RD_LAT) begin
                v[38]    = 1'b1;
                v[37:27] = 11'(b);
                v[7:0]   = ram[i][a];
            end
        end
        return v;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    string       lit_name [128];
    logic [63:0] lit_a [128];
    logic [63:0] lit_e [128];
    int lit_wr = 0;
    int lit_rd = 0;

    int wr_cnt [2], we_cnt [2], done_cnt [2], done_cyc [2], pause_cnt [2];
    logic [18:0] wr0_q [$];
    logic [18:0] we0_q [$];
    logic [10:0] wr1_q [$];
    logic [10:0] fetch1_q [$];

    always @(negedge MCLK) begin
        for (int i = 0; i < 2; i++) begin
            logic [43:0] e;
            e = model_out(i);
            n_tests++;
            if (obs[i] !== e) begin
                n_fail++;
                $display("FAIL out%0d cycle %0d: got %h expected %h", i, cyc, obs[i], e);
            end
            if (obs[i][39]) begin
                wr_cnt[i]++;
                if (i == 0) wr0_q.push_back({obs[i][26:16], obs[i][15:8]});
                else        wr1_q.push_back(obs[i][26:16]);
            end
            if (obs[i][38]) begin
                we_cnt[i]++;
                if (i == 0) we0_q.push_back({obs[i][37:27], obs[i][7:0]});
            end
            if (obs[i][41]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
            if (obs[i][43]) pause_cnt[i]++;
            if (i == 1 && obs[i][40] && !obs[i][39] && obs[i][43]) fetch1_q.push_back(obs[i][37:27]);
        end
        while (lit_rd < lit_wr) begin
            n_tests++;
            if (lit_a[lit_rd] !== lit_e[lit_rd]) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", lit_name[lit_rd], lit_a[lit_rd], lit_e[lit_rd]);
            end
            lit_rd++;
        end
    end

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        lit_name[lit_wr] = nm;
        lit_a[lit_wr]    = a;
        lit_e[lit_wr]    = e;
        lit_wr++;
    endtask

    task automatic set_mem(logic [31:0] bv, logic [31:0] rv);
        for (int j = 0; j < 4; j++) begin
            init_buf[j] = bv[31-8*j -: 8];
            init_ram[j] = rv[31-8*j -: 8];
        end
        mem_init = 1'b1;
        @(posedge MCLK); #1;
        mem_init = 1'b0;
    endtask

    task automatic pulse(int i, logic l, logic sr, output int st);
        @(posedge MCLK); #1;
        ld[i] = l;
        sv[i] = sr;
        st    = cyc;
        @(posedge MCLK); #1;
        ld[i] = 1'b0;
        sv[i] = 1'b0;
    endtask

    task automatic wait_done(int i, int d0, string nm);
        int c = 0;
        while (done_cnt[i] == d0 && c < 200) begin
            @(posedge MCLK);
            c++;
        end
        #1;
        chk({nm, "_done_seen"}, 64'(done_cnt[i] - d0), 64'd1);
    endtask

    logic [7:0]  ldb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  svb [4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    logic [7:0]  b6  [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [10:0] a6  [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

    initial begin
        int st, st2, d0, w0, e0, p0, q0, q1, c;
        ld[0] = 1'b0; ld[1] = 1'b0; sv[0] = 1'b0; sv[1] = 1'b0;
        mem_init = 1'b0;
        for (int j = 0; j < 4; j++) begin init_buf[j] = 8'h00; init_ram[j] = 8'h00; end
        repeat (3) @(posedge MCLK);
        #1 RESET = 1'b0;
        chk("reset_out0", 64'(obs[0]), 64'd0);
        chk("reset_out1", 64'(obs[1]), 64'd0);

        // load 11,22,33,44 into core 000..003
        set_mem(32'h11223344, 32'h0);
        d0 = done_cnt[0]; w0 = wr_cnt[0]; e0 = we_cnt[0]; p0 = pause_cnt[0]; q0 = wr0_q.size();
        pulse(0, 1'b1, 1'b0, st);
        wait_done(0, d0, "load");
        chk("load_done_cycle", 64'(done_cyc[0] - st), 64'd13);
        chk("load_pause_cycles", 64'(pause_cnt[0] - p0), 64'd12);
        chk("load_writes", 64'(wr_cnt[0] - w0), 64'd4);
        chk("load_buf_we", 64'(we_cnt[0] - e0), 64'd0);
        if (wr0_q.size() >= q0 + 4)
            for (int j = 0; j < 4; j++) chk("load_write_addr_data", 64'(wr0_q[q0+j]), 64'({11'(j), ldb[j]}));
        for (int j = 0; j < 4; j++) chk("load_core_ram", 64'(ram[0][j]), 64'(ldb[j]));

        // save core A5,5A,C3,3C into buffer
        set_mem(32'h0, 32'hA55AC33C);
        d0 = done_cnt[0]; w0 = wr_cnt[0]; e0 = we_cnt[0]; q0 = we0_q.size();
        pulse(0, 1'b0, 1'b1, st);
        wait_done(0, d0, "save");
        chk("save_done_cycle", 64'(done_cyc[0] - st), 64'd17);
        chk("save_hs_write", 64'(wr_cnt[0] - w0), 64'd0);
        chk("save_buf_we", 64'(we_cnt[0] - e0), 64'd4);
        if (we0_q.size() >= q0 + 4)
            for (int j = 0; j < 4; j++) chk("save_we_ad_data", 64'(we0_q[q0+j]), 64'({11'(j), svb[j]}));
        for (int j = 0; j < 4; j++) chk("save_host_buf", 64'(hbuf[0][j]), 64'(svb[j]));

        // simultaneous requests and a save pulsed mid-load
        set_mem(32'h11223344, 32'h0);
        d0 = done_cnt[0]; w0 = wr_cnt[0]; e0 = we_cnt[0];
        pulse(0, 1'b1, 1'b1, st);
        repeat (3) @(posedge MCLK);
        pulse(0, 1'b0, 1'b1, st2);
        wait_done(0, d0, "both");
        repeat (25) @(posedge MCLK);
        #1;
        chk("both_done_cycle", 64'(done_cyc[0] - st), 64'd13);
        chk("both_hs_write", 64'(wr_cnt[0] - w0), 64'd4);
        chk("both_buf_we", 64'(we_cnt[0] - e0), 64'd0);
        chk("both_done_count", 64'(done_cnt[0] - d0), 64'd1);

        // reset during save after byte 1, then a full restart
        set_mem(32'h0, 32'hA55AC33C);
        d0 = done_cnt[0]; e0 = we_cnt[0];
        pulse(0, 1'b0, 1'b1, st);
        c = 0;
        while (we_cnt[0] - e0 < 2 && c < 100) begin
            @(posedge MCLK);
            c++;
        end
        chk("abort_two_bytes", 64'(we_cnt[0] - e0), 64'd2);
        @(posedge MCLK); #3;
        RESET = 1'b1;
        #1;
        chk("abort_outputs_zero", 64'(obs[0]), 64'd0);
        chk("abort_pause", 64'(obs[0][43]), 64'd0);
        repeat (2) @(posedge MCLK);
        #1 RESET = 1'b0;
        repeat (30) @(posedge MCLK);
        #1;
        chk("abort_no_done", 64'(done_cnt[0] - d0), 64'd0);
        set_mem(32'h0, 32'hA55AC33C);
        d0 = done_cnt[0]; e0 = we_cnt[0]; q0 = we0_q.size();
        pulse(0, 1'b0, 1'b1, st);
        wait_done(0, d0, "resave");
        chk("resave_done_cycle", 64'(done_cyc[0] - st), 64'd17);
        chk("resave_buf_we", 64'(we_cnt[0] - e0), 64'd4);
        if (we0_q.size() >= q0 + 4)
            for (int j = 0; j < 4; j++) chk("resave_we_ad_data", 64'(we0_q[q0+j]), 64'({11'(j), svb[j]}));
        for (int j = 0; j < 4; j++) chk("resave_host_buf", 64'(hbuf[0][j]), 64'(svb[j]));

        // asynchronous reset in the middle of a load
        set_mem(32'h11223344, 32'h0);
        d0 = done_cnt[0];
        pulse(0, 1'b1, 1'b0, st);
        repeat (6) @(posedge MCLK);
        @(posedge MCLK); #3;
        RESET = 1'b1;
        #1;
        chk("async_outputs_zero", 64'(obs[0]), 64'd0);
        chk("async_busy", 64'(obs[0][42]), 64'd0);
        repeat (2) @(posedge MCLK);
        #1 RESET = 1'b0;
        repeat (20) @(posedge MCLK);
        #1;
        chk("async_no_done", 64'(done_cnt[0] - d0), 64'd0);

        // wrapping core address window on the second instance
        set_mem(32'hDEADBEEF, 32'h0);
        d0 = done_cnt[1]; q0 = wr1_q.size(); q1 = fetch1_q.size();
        pulse(1, 1'b1, 1'b0, st);
        wait_done(1, d0, "wrap");
        chk("wrap_done_cycle", 64'(done_cyc[1] - st), 64'd13);
        chk("wrap_write_count", 64'(wr1_q.size() - q0), 64'd4);
        chk("wrap_fetch_count", 64'(fetch1_q.size() - q1), 64'd4);
        if (wr1_q.size() >= q0 + 4)
            for (int j = 0; j < 4; j++) chk("wrap_hs_address", 64'(wr1_q[q0+j]), 64'(a6[j]));
        if (fetch1_q.size() >= q1 + 4)
            for (int j = 0; j < 4; j++) chk("wrap_buf_ad", 64'(fetch1_q[q1+j]), 64'(j));
        for (int j = 0; j < 4; j++) chk("wrap_core_ram", 64'(ram[1][a6[j]]), 64'(b6[j]));

        repeat (3) @(negedge MCLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
